// File: rtl/func_scheduler.sv
// Round-robin scheduler sharing one cube unit and one square-root unit between two requesters.
// Optional watchdog abort is enabled by defining FUNC_SCHED_WATCHDOG_EN.
`timescale 1ns/1ps
module func_scheduler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [15:0] arg0_bi,
    input  logic [15:0] arg1_bi,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [15:0] result_bo,
    output logic        busy_o,
    output logic        err_o,
    output logic        cube_start_o,
    output logic [7:0]  cube_a_bo,
    input  logic        cube_busy_i,
    input  logic [15:0] cube_y_bi,
    output logic        root_start_o,
    output logic [7:0]  root_x_bo,
    input  logic        root_busy_i,
    input  logic [3:0]  root_y_bi
);

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            seen_cube_q, seen_cube_d;
    logic            seen_root_q, seen_root_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            done0_q, done0_d, done1_q, done1_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   result_q, result_d;
    logic [OW-1:0]   opa_q, opa_d;
    logic [OW-1:0]   opb_q, opb_d;
    logic            grant;
    logic            grant_sel;

`ifdef FUNC_SCHED_WATCHDOG_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    logic            wd_abort;
`endif

    // Arbitration, handshake sequencing and next values of every registered output
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        seen_cube_d = seen_cube_q;
        seen_root_d = seen_root_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        start_d     = 1'b0;
        result_d    = result_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        grant       = 1'b0;
        grant_sel   = 1'b0;
`ifdef FUNC_SCHED_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
        wd_abort    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req0_i && req1_i) begin
                    grant     = 1'b1;
                    grant_sel = ~last_q;
                end else if (req0_i) begin
                    grant     = 1'b1;
                    grant_sel = 1'b0;
                end else if (req1_i) begin
                    grant     = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant) begin
                    owner_d = grant_sel;
                    opa_d   = grant_sel ? arg1_bi[15:8] : arg0_bi[15:8];
                    opb_d   = grant_sel ? arg1_bi[7:0]  : arg0_bi[7:0];
                    ack0_d  = ~grant_sel;
                    ack1_d  = grant_sel;
                    start_d = 1'b1;
                    state_d = ISSUE;
`ifdef FUNC_SCHED_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                seen_cube_d = 1'b0;
                seen_root_d = 1'b0;
                state_d     = WAIT;
`ifdef FUNC_SCHED_WATCHDOG_EN
                wd_cnt_d    = '0;
`endif
            end
            WAIT: begin
                seen_cube_d = seen_cube_q | cube_busy_i;
                seen_root_d = seen_root_q | root_busy_i;
`ifdef FUNC_SCHED_WATCHDOG_EN
                wd_cnt_d = wd_cnt_q + CW'(1);
                wd_abort = ((wd_cnt_q == CW'(2)) && !(seen_cube_d && seen_root_d))
                         || (wd_cnt_q == CW'(254));
`endif
                // Completion only via the busy handshake, so zero results still finish
                if (seen_cube_q && seen_root_q && !cube_busy_i && !root_busy_i) begin
                    result_d = cube_y_bi + DW'(root_y_bi);
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    state_d  = RESP;
                end
`ifdef FUNC_SCHED_WATCHDOG_EN
                else if (wd_abort) begin
                    result_d = {DW{1'b1}};
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    err_d    = 1'b1;
                    last_d   = owner_q;
                    state_d  = IDLE;
                end
`endif
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            seen_cube_q <= 1'b0;
            seen_root_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            seen_cube_q <= seen_cube_d;
            seen_root_q <= seen_root_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
        end
    end

`ifdef FUNC_SCHED_WATCHDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ack0_o       = ack0_q;
    assign ack1_o       = ack1_q;
    assign done0_o      = done0_q;
    assign done1_o      = done1_q;
    assign result_bo    = result_q;
    assign busy_o       = busy_q;
    assign cube_start_o = start_q;
    assign root_start_o = start_q;
    assign cube_a_bo    = opa_q;
    assign root_x_bo    = opb_q;

endmodule

// File: doc/func_scheduler.md
# func_scheduler

Shares one cube unit and one square-root unit between two requesters and computes y = a³ + ⌊√b⌋ for the granted requester. It provides round-robin arbitration, a start/busy handshake to both units and a per-requester completion pulse. It sits between the switch/host front ends and the existing cube and root datapaths. It replaces per-requester copies of those units.

## Interface
- No parameters; all widths are fixed.
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous reset, active-high
- req0_i / req1_i  in  1  level request from requester 0 / 1
- arg0_bi / arg1_bi  in  16  operands: [15:8] = a, [7:0] = b
- ack0_o / ack1_o  out  1  one-cycle pulse; the request is granted and its operands are latched
- done0_o / done1_o  out  1  one-cycle pulse; result_bo is valid for that requester
- result_bo  out  16  last result, held until the next completion
- busy_o  out  1  high whenever state ≠ IDLE
- err_o  out  1  watchdog abort flag (see Configuration); tie-low otherwise
- cube_start_o  out  1  start strobe to the cube unit
- cube_a_bo  out  8  operand to the cube unit
- cube_busy_i  in  1  busy from the cube unit
- cube_y_bi  in  16  result from the cube unit
- root_start_o  out  1  start strobe to the root unit
- root_x_bo  out  8  operand to the root unit
- root_busy_i  in  1  busy from the root unit
- root_y_bi  in  4  result from the root unit

## Operation
- **Reset values:**
  - all outputs are 0
  - state = IDLE
  - last_grant = 1, so requester 0 wins the first tie
  - seen flags are cleared
- **IDLE:**
  - With exactly one request high, grant that requester.
  - With both requests high, grant the requester ≠ last_grant.
  - On grant: latch a and b from that requester's arg onto cube_a_bo/root_x_bo, pulse its ack, record the owner, go to ISSUE.
- **ISSUE:**
  - Assert cube_start_o and root_start_o for exactly this one cycle.
  - Clear seen_cube and seen_root.
  - Go to WAIT.
- **WAIT:**
  - Set seen_cube once cube_busy_i is sampled high; set seen_root once root_busy_i is sampled high.
  - Leave WAIT when seen_cube and seen_root are both set and cube_busy_i and root_busy_i are both low.
  - Completion is detected only through the busy handshake, never by a non-zero result, so a = 0 and b = 0 must complete.
- **RESP:**
  - result_bo ← cube_y_bi + {12'b0, root_y_bi}, modulo 2¹⁶.
  - Pulse the owner's done.
  - last_grant ← owner.
  - Return to IDLE.
- Operands on cube_a_bo/root_x_bo stay stable from the grant until RESP. Changes on argN_bi after the grant are ignored.
- A request still high in IDLE after its done is re-arbitrated like any other request. Round-robin alternates 0, 1, 0, … while both requesters hold their requests.
- A request dropped before grant is never granted. Dropping a request after grant does not abort the operation.

## Timing
- Grant happens in the first IDLE cycle in which a request is sampled high; ack is registered and visible the following cycle.
- Start strobes are high for exactly 1 cycle.
- Latency from ack to done = 1 (ISSUE) + unit busy duration of the slower unit + 1 (RESP).
- busy_o rises in the cycle after grant. It falls in the cycle after the done pulse, when the state is back in IDLE.
- Back-to-back: a request held high is granted on the first IDLE cycle after RESP, with no bubble beyond that IDLE cycle.
- Reset asserted mid-operation:
  - Immediate return to IDLE; outputs and seen flags clear asynchronously.
  - No done pulse is produced.
  - The units share rst_i.
- ack and done for the same requester are never high in the same cycle.

## Configuration
- Macro: FUNC_SCHED_WATCHDOG_EN.
- When defined:
  - An 8-bit counter runs in WAIT.
  - If either seen flag is still clear 4 cycles after ISSUE, or WAIT lasts 255 cycles, set err_o, pulse the owner's done with result_bo = 16'hFFFF, and return to IDLE.
  - err_o is sticky until rst_i or the next grant.
- When undefined:
  - No counter is built; err_o is constant 0.
  - WAIT can last indefinitely.

## Test plan
- **Single request:** req0 with arg0 = 16'h0310 (a = 3, b = 16) → ack0 is seen, then done0 with result_bo = 31. busy_o is high from the cycle after grant through RESP.
- **Zero operands:** req1 with arg1 = 16'h0000 → done1 with result_bo = 0. There must be no hang, because completion is detected from busy.
- **Wrap:** arg0 = 16'hFFFF (a = 255, b = 255) → result_bo = 767 + 15 = 782.
- **Fairness:**
  - req0 and req1 asserted together right after reset and held for 4 operations → grant order is 0, 1, 0, 1.
  - Each done pulse goes to the requester that was granted.
- **Reset mid-op:** assert rst_i 3 cycles into WAIT → all outputs are 0 immediately and no done pulse occurs. After release, a new req0 completes normally.
- **Watchdog (macro defined):** hold cube_busy_i at 0 after ISSUE → err_o = 1 and done0 with result_bo = 16'hFFFF on the 4th WAIT cycle. With the macro undefined, busy_o stays high.
